sram_oq_writer: RTL and testbench
=================================

Name: sram_oq_writer

Overview:
- Memory-clock-side stage that drains the packed 202-bit packet-word FIFO filled by the AXI-to-FIFO packer.
- Decodes each packet's destination output queue from its header word and writes the packet into that queue's circular region of external SRAM.
- Tracks free space per queue and publishes committed write pointers to the SRAM read-out stage.
- Only whole packets become visible downstream; packets that do not fit are dropped whole.

Parameters:
- WORD_WIDTH, 202, packed word: [201:10] payload, [9:5] strobe count, [4:2] segment state, [1] last, [0] write flag
- NUM_QUEUES, 5, output queues
- ADDR_WIDTH, 19, SRAM word address width
- QUEUE_SIZE, 104857, words per queue region; queue q base address = q*QUEUE_SIZE
- DST_POS, 24, bit offset of the one-hot destination byte in the header tuser field (word bits [137:10])

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_data  in  WORD_WIDTH  head word of the fall-through FIFO
- in_empty  in  1  FIFO empty
- in_rd_en  out  1  pop the head word
- sram_wr_req  out  1  write request
- sram_wr_addr  out  ADDR_WIDTH  write address
- sram_wr_data  out  WORD_WIDTH  write data
- sram_wr_ready  in  1  write accepted this cycle when req & ready
- rel_valid  in  1  reader released words
- rel_q  in  3  queue being released
- rel_words  in  ADDR_WIDTH  number of words released
- commit_ptr  out  NUM_QUEUES*ADDR_WIDTH  per-queue committed write offset, queue 0 in the LSBs
- pkt_commit  out  1  one-cycle pulse when a packet is committed
- pkt_commit_q  out  3  queue of the committed packet
- drop_cnt  out  32  packets dropped (saturates)

Behaviour:
- Reset values:
  - outputs: all 0
  - state: IDLE
  - free[q]: QUEUE_SIZE
  - wr_off[q]: 0
  - commit_ptr: 0
- Queue decode from header byte H = tuser[DST_POS+7:DST_POS]:
  - H[0]→q0, H[2]→q1, H[4]→q2, H[6]→q3; any odd bit set→q4.
  - Multiple bits set: lowest queue index wins.
  - H == 0: no queue.
- Length check: L = tuser[15:0] in bytes. Packet accepted iff free[q] >= (L>>4)+2. This is a conservative bound for 24-byte payload words plus the header word.
- FSM:
  - IDLE: wait for !in_empty. Latch the queue decode of in_data without popping. Go to CHECK.
  - CHECK (1 cycle):
    - No queue, or length check fails → DROP; drop_cnt increments.
    - Otherwise → WRITE; latch cur_q, pkt_words = 0.
  - WRITE:
    - sram_wr_req = !in_empty.
    - sram_wr_addr = cur_q*QUEUE_SIZE + wr_off[cur_q].
    - sram_wr_data = in_data, passed through unmodified; the header word is stored too.
    - in_rd_en = req & sram_wr_ready.
    - On each accepted word: wr_off advances, wrapping from QUEUE_SIZE-1 to 0; free[cur_q] decrements; pkt_words increments.
    - Accepted word with bit[1] set: next cycle commit_ptr[cur_q] = wr_off[cur_q], pkt_commit pulses with pkt_commit_q = cur_q, state → IDLE.
  - DROP: in_rd_en = !in_empty. Pop words up to and including the one with bit[1] set, then → IDLE.
- Overflow abort: in WRITE with a word pending and free[cur_q] == 0:
  - Assert no req.
  - Rewind wr_off[cur_q] to commit_ptr[cur_q].
  - Restore free[cur_q] += pkt_words.
  - drop_cnt increments; → DROP. The pending word is dropped by DROP, including when it is the last word.
- Release:
  - rel_valid adds rel_words to free[rel_q] in the same cycle as any decrement or restore; the net change is applied once.
  - A result exceeding QUEUE_SIZE clamps to QUEUE_SIZE.
  - rel_q >= NUM_QUEUES is ignored.
- SRAM stall: sram_wr_ready low holds req/addr/data stable; no pop.
- Reset mid-packet: all state is discarded and any partial packet stays invisible, because commit_ptr resets to 0. The upstream FIFO is reset by the same reset.
- Throughput: 1 word/cycle in WRITE. Per-packet overhead: 2 cycles (IDLE and CHECK) plus 1 commit cycle; the commit cycle overlaps IDLE.

Decomposition:
- Package sram_oq_pkg holds:
  - word field offsets: PAYLOAD_LSB = 10, STRB_LSB = 5, SEG_LSB = 2, LAST_BIT = 1, WREN_BIT = 0
  - NUM_QUEUES, QUEUE_SIZE, DST_POS
  - FSM state enum {IDLE, CHECK, WRITE, DROP}
  - the dst_to_queue decode function
- One sub-module: oq_free_space. It holds the per-queue free counters and applies decrement, abort-restore and release plus clamp; it is shared with the reader-side accounting.

Test Plan:
- Header H = 0x01, L = 64, header + 3 words → SRAM writes at addresses 0..3; pkt_commit with q = 0; commit_ptr[0] = 4; free[0] = QUEUE_SIZE-4.
- Header H = 0x02 (odd bit) → writes start at base 4*QUEUE_SIZE = 419428; pkt_commit_q = 4.
- H = 0x00 → whole packet popped, no sram_wr_req, drop_cnt = 1; the next valid packet is written normally.
- wr_off[1] = QUEUE_SIZE-2, 4-word packet → addresses 2*QUEUE_SIZE-2, 2*QUEUE_SIZE-1, QUEUE_SIZE, QUEUE_SIZE+1; commit_ptr[1] = 2.
- free[2] = 3, then a packet with lying L = 16 and 6 words → 3 words written, abort; wr_off[2] rewinds; free[2] = 3; drop_cnt +1; no pkt_commit.
- sram_wr_ready low for 5 cycles mid-packet while rel_valid, q = 0, 10 words → addr/data held, no pops; free[0] ends with net +10 minus words written, clamped at QUEUE_SIZE.

Source files
------------

// File: rtl/sram_oq_writer_pkg.sv
// Shared constants, FSM state type and destination decode for the SRAM output-queue writer.
package sram_oq_pkg;

    localparam int unsigned WORD_WIDTH = 202;
    localparam int unsigned ADDR_WIDTH = 19;
    localparam int unsigned NUM_QUEUES = 5;
    localparam int unsigned QID_WIDTH  = 3;
    localparam int unsigned QUEUE_SIZE = 104857;
    localparam int unsigned DST_POS    = 24;

    // Packed word layout
    localparam int unsigned PAYLOAD_LSB = 10;
    localparam int unsigned STRB_LSB    = 5;
    localparam int unsigned SEG_LSB     = 2;
    localparam int unsigned LAST_BIT    = 1;
    localparam int unsigned WREN_BIT    = 0;

    // Header tuser occupies payload bits [127:0]; length in tuser[15:0]
    localparam int unsigned LEN_LSB = PAYLOAD_LSB;
    localparam int unsigned DST_LSB = PAYLOAD_LSB + DST_POS;

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DROP} state_t;

    typedef struct packed {
        logic                 valid;
        logic [QID_WIDTH-1:0] q;
    } qsel_t;

    // Even bits map to queues 0..3, any odd bit to queue 4; lowest queue index wins.
    function automatic qsel_t dst_to_queue(input logic [7:0] h);
        qsel_t r;
        r.valid = 1'b1;
        r.q     = '0;
        if (h[0])                             r.q = 3'd0;
        else if (h[2])                        r.q = 3'd1;
        else if (h[4])                        r.q = 3'd2;
        else if (h[6])                        r.q = 3'd3;
        else if (|{h[7], h[5], h[3], h[1]})   r.q = 3'd4;
        else                                  r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/sram_oq_writer_if.sv
// SRAM write port: request/address/data from the writer, ready from the memory controller.
interface sram_oq_writer_if;

    logic                                 sram_wr_req;
    logic [sram_oq_pkg::ADDR_WIDTH-1:0]   sram_wr_addr;
    logic [sram_oq_pkg::WORD_WIDTH-1:0]   sram_wr_data;
    logic                                 sram_wr_ready;

    modport master (
        output sram_wr_req,
        output sram_wr_addr,
        output sram_wr_data,
        input  sram_wr_ready
    );

    modport slave (
        input  sram_wr_req,
        input  sram_wr_addr,
        input  sram_wr_data,
        output sram_wr_ready
    );

endinterface

// File: rtl/sram_oq_writer_free_space.sv
// Per-queue free-word counters: write decrement, abort restore and reader release, clamped
// to the queue size. All three adjustments to one queue in a cycle are summed and applied once.
module oq_free_space
    import sram_oq_pkg::*;
#(
    parameter int unsigned QueueSize = QUEUE_SIZE
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_dec,
    input  logic [QID_WIDTH-1:0]                  i_dec_q,
    input  logic                                  i_restore,
    input  logic [QID_WIDTH-1:0]                  i_restore_q,
    input  logic [ADDR_WIDTH-1:0]                 i_restore_words,
    input  logic                                  i_rel_valid,
    input  logic [QID_WIDTH-1:0]                  i_rel_q,
    input  logic [ADDR_WIDTH-1:0]                 i_rel_words,
    output logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] o_free
);

    // Two guard bits: free + release + restore cannot overflow before the clamp
    localparam int unsigned SUM_W = ADDR_WIDTH + 2;

    logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] r_free;
    logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] w_free_d;
    logic [NUM_QUEUES-1:0][SUM_W-1:0]      w_sum;

    // Net change per queue, then clamp; a decrement only happens when free is non-zero
    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            w_sum[q] = {2'b00, r_free[q]};
            if (i_rel_valid && (i_rel_q == QID_WIDTH'(q))) begin
                w_sum[q] = w_sum[q] + {2'b00, i_rel_words};
            end
            if (i_restore && (i_restore_q == QID_WIDTH'(q))) begin
                w_sum[q] = w_sum[q] + {2'b00, i_restore_words};
            end
            if (i_dec && (i_dec_q == QID_WIDTH'(q))) begin
                w_sum[q] = w_sum[q] - SUM_W'(1);
            end
            w_free_d[q] = (w_sum[q] > SUM_W'(QueueSize)) ? ADDR_WIDTH'(QueueSize)
                                                         : w_sum[q][ADDR_WIDTH-1:0];
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                r_free[q] <= ADDR_WIDTH'(QueueSize);
            end
        end else begin
            r_free <= w_free_d;
        end
    end

    assign o_free = r_free;

endmodule

// File: rtl/sram_oq_writer.sv
// Drains packed packet words, steers each packet into its output queue's SRAM ring and
// publishes the write pointer only once the whole packet has landed.
module sram_oq_writer
    import sram_oq_pkg::*;
#(
    parameter int unsigned QueueSize = QUEUE_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [WORD_WIDTH-1:0]            in_data,
    input  logic                             in_empty,
    output logic                             in_rd_en,
    sram_oq_writer_if.master                 sram,
    input  logic                             rel_valid,
    input  logic [QID_WIDTH-1:0]             rel_q,
    input  logic [ADDR_WIDTH-1:0]            rel_words,
    output logic [NUM_QUEUES*ADDR_WIDTH-1:0] commit_ptr,
    output logic                             pkt_commit,
    output logic [QID_WIDTH-1:0]             pkt_commit_q,
    output logic [31:0]                      drop_cnt
);

    state_t                                r_state;
    qsel_t                                 r_hdr;
    logic [ADDR_WIDTH-1:0]                 r_need;
    logic [QID_WIDTH-1:0]                  r_cur_q;
    logic [ADDR_WIDTH-1:0]                 r_pkt_words;
    logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] r_wr_off;
    logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] r_commit;
    logic                                  r_pkt_commit;
    logic [QID_WIDTH-1:0]                  r_pkt_commit_q;
    logic [31:0]                           r_drop_cnt;

    logic [NUM_QUEUES-1:0][ADDR_WIDTH-1:0] w_free;
    logic [ADDR_WIDTH-1:0]                 w_cur_free;
    logic [ADDR_WIDTH-1:0]                 w_cur_off;
    logic [ADDR_WIDTH-1:0]                 w_off_inc;
    logic [ADDR_WIDTH-1:0]                 w_base;
    logic                                  w_pending;
    logic                                  w_abort;
    logic                                  w_req;
    logic                                  w_accept;
    logic                                  w_fits;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Write-side datapath; abort suppresses the request when the ring is full mid-packet
    always_comb begin
        w_cur_free = w_free[r_cur_q];
        w_cur_off  = r_wr_off[r_cur_q];
        w_off_inc  = (w_cur_off == ADDR_WIDTH'(QueueSize - 1)) ? '0 : w_cur_off + 1'b1;
        w_base     = ADDR_WIDTH'(32'(r_cur_q) * QueueSize);
        w_pending  = (r_state == WRITE) && !in_empty;
        w_abort    = w_pending && (w_cur_free == '0);
        w_req      = w_pending && !w_abort;
        w_accept   = w_req && sram.sram_wr_ready;
        w_fits     = (w_free[r_hdr.q] >= r_need);
    end

    assign sram.sram_wr_req  = w_req;
    assign sram.sram_wr_addr = w_base + w_cur_off;
    assign sram.sram_wr_data = in_data;
    assign in_rd_en          = w_accept || ((r_state == DROP) && !in_empty);

    oq_free_space #(
        .QueueSize (QueueSize)
    ) u_free (
        .clk             (clk),
        .reset           (reset),
        .i_dec           (w_accept),
        .i_dec_q         (r_cur_q),
        .i_restore       (w_abort),
        .i_restore_q     (r_cur_q),
        .i_restore_words (r_pkt_words),
        .i_rel_valid     (rel_valid),
        .i_rel_q         (rel_q),
        .i_rel_words     (rel_words),
        .o_free          (w_free)
    );

    // Packet FSM with per-queue offsets, commit pointers and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_hdr          <= '0;
            r_need         <= '0;
            r_cur_q        <= '0;
            r_pkt_words    <= '0;
            r_wr_off       <= '0;
            r_commit       <= '0;
            r_pkt_commit   <= 1'b0;
            r_pkt_commit_q <= '0;
            r_drop_cnt     <= '0;
        end else begin
            r_pkt_commit <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // Header is only peeked here; it is popped as the first written word
                    if (!in_empty) begin
                        r_hdr   <= dst_to_queue(in_data[DST_LSB +: 8]);
                        r_need  <= ADDR_WIDTH'(in_data[LEN_LSB +: 16] >> 4) + ADDR_WIDTH'(2);
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!r_hdr.valid || !w_fits) begin
                        r_drop_cnt <= sat_inc(r_drop_cnt);
                        r_state    <= DROP;
                    end else begin
                        r_cur_q     <= r_hdr.q;
                        r_pkt_words <= '0;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_abort) begin
                        // Discard the partial packet; free space is restored in oq_free_space
                        r_wr_off[r_cur_q] <= r_commit[r_cur_q];
                        r_drop_cnt        <= sat_inc(r_drop_cnt);
                        r_state           <= DROP;
                    end else if (w_accept) begin
                        r_wr_off[r_cur_q] <= w_off_inc;
                        r_pkt_words       <= r_pkt_words + 1'b1;
                        if (in_data[LAST_BIT]) begin
                            r_commit[r_cur_q] <= w_off_inc;
                            r_pkt_commit      <= 1'b1;
                            r_pkt_commit_q    <= r_cur_q;
                            r_state           <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (!in_empty && in_data[LAST_BIT]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign commit_ptr   = r_commit;
    assign pkt_commit   = r_pkt_commit;
    assign pkt_commit_q = r_pkt_commit_q;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_sram_oq_writer.sv
// Directed bench for sram_oq_writer with a small queue size so wrap, fill and abort are reachable.
module tb_sram_oq_writer;
    import sram_oq_pkg::*;

    localparam int unsigned QS = 32;

    logic                             clk;
    logic                             reset;
    logic [WORD_WIDTH-1:0]            in_data;
    logic                             in_empty;
    logic                             in_rd_en;
    logic                             rel_valid;
    logic [QID_WIDTH-1:0]             rel_q;
    logic [ADDR_WIDTH-1:0]            rel_words;
    logic [NUM_QUEUES*ADDR_WIDTH-1:0] commit_ptr;
    logic                             pkt_commit;
    logic [QID_WIDTH-1:0]             pkt_commit_q;
    logic [31:0]                      drop_cnt;

    sram_oq_writer_if sram_if ();

    sram_oq_writer #(
        .QueueSize (QS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_empty     (in_empty),
        .in_rd_en     (in_rd_en),
        .sram         (sram_if),
        .rel_valid    (rel_valid),
        .rel_q        (rel_q),
        .rel_words    (rel_words),
        .commit_ptr   (commit_ptr),
        .pkt_commit   (pkt_commit),
        .pkt_commit_q (pkt_commit_q),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fall-through FIFO model: head word always visible, popped on in_rd_en
    logic [WORD_WIDTH-1:0] fifo_mem [0:511];
    int unsigned wp = 0;
    int unsigned rp = 0;
    assign in_data  = fifo_mem[rp[8:0]];
    assign in_empty = (rp == wp);

    logic [ADDR_WIDTH-1:0] wr_addr_log [$];
    logic [WORD_WIDTH-1:0] wr_data_log [$];
    int                    commit_cnt = 0;
    logic [QID_WIDTH-1:0]  last_commit_q = '0;

    always @(posedge clk) begin
        if (!reset) begin
            if (in_rd_en && (rp != wp)) rp <= rp + 1;
            if (sram_if.sram_wr_req && sram_if.sram_wr_ready) begin
                wr_addr_log.push_back(sram_if.sram_wr_addr);
                wr_data_log.push_back(sram_if.sram_wr_data);
            end
            if (pkt_commit) begin
                commit_cnt    <= commit_cnt + 1;
                last_commit_q <= pkt_commit_q;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [WORD_WIDTH-1:0] obs,
                            input logic [WORD_WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_WIDTH-1:0] cptr(input int q);
        return commit_ptr[q*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] free_of(input int q);
        return dut.w_free[q];
    endfunction

    // Header carries dst byte and length; all words carry a tag/index pattern in the payload
    task automatic push_pkt(input logic [7:0] h, input logic [15:0] len, input int nwords,
                            input logic [7:0] tag, output int unsigned start);
        logic [WORD_WIDTH-1:0] w;
        start = wp;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            w[201:170] = {tag, 8'(i), 16'hA55A};
            w[137:42]  = {24'hC0FFEE, tag, 8'(i), 56'h0};
            if (i == 0) begin
                w[41:34] = h;
                w[25:10] = len;
            end else begin
                w[41:10] = {tag, 8'(i), 16'h5AA5};
            end
            w[9:5] = 5'd24;
            w[1]   = (i == nwords - 1);
            w[0]   = 1'b1;
            fifo_mem[wp[8:0]] = w;
            wp = wp + 1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((rp != wp) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_fifo_left"}, wp - rp, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int base, input int n,
                                input logic [ADDR_WIDTH-1:0] addr0, input int unsigned start,
                                input int wrap_at);
        logic [ADDR_WIDTH-1:0] a;
        check_eq({tag, "_nwr"}, wr_addr_log.size(), base + n);
        for (int k = 0; k < n; k++) begin
            a = (k >= wrap_at) ? addr0 + ADDR_WIDTH'(k) - ADDR_WIDTH'(QS) : addr0 + ADDR_WIDTH'(k);
            if (base + k < wr_addr_log.size()) begin
                check_eq({tag, "_addr"}, wr_addr_log[base + k], a);
                check_eq({tag, "_data"}, wr_data_log[base + k], fifo_mem[(start + k) % 512]);
            end
        end
    endtask

    initial begin
        int          base;
        int unsigned s;
        int          n;

        reset     = 1'b1;
        rel_valid = 1'b0;
        rel_q     = '0;
        rel_words = '0;
        sram_if.sram_wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_eq("rst_req", sram_if.sram_wr_req, 0);
        check_eq("rst_rd_en", in_rd_en, 0);
        check_eq("rst_commit_ptr", commit_ptr, 0);
        check_eq("rst_pkt_commit", pkt_commit, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        check_eq("rst_free0", free_of(0), QS);
        check_eq("rst_free4", free_of(4), QS);

        // q0, header + 3 words
        base = wr_addr_log.size();
        push_pkt(8'h01, 16'd64, 4, 8'h11, s);
        drain("t1");
        check_writes("t1", base, 4, 0, s, 99);
        check_eq("t1_commits", commit_cnt, 1);
        check_eq("t1_commit_q", last_commit_q, 0);
        check_eq("t1_cptr0", cptr(0), 4);
        check_eq("t1_free0", free_of(0), QS - 4);

        // Odd bit -> q4
        base = wr_addr_log.size();
        push_pkt(8'h02, 16'd16, 3, 8'h22, s);
        drain("t2");
        check_writes("t2", base, 3, 4 * QS, s, 99);
        check_eq("t2_commit_q", last_commit_q, 4);
        check_eq("t2_cptr4", cptr(4), 3);

        // No destination -> dropped whole
        base = wr_addr_log.size();
        push_pkt(8'h00, 16'd16, 3, 8'h33, s);
        drain("t3");
        check_eq("t3_nwr", wr_addr_log.size(), base);
        check_eq("t3_drop", drop_cnt, 1);
        check_eq("t3_commits", commit_cnt, 2);
        // Bits 2 and 4 -> q1 (lowest index)
        base = wr_addr_log.size();
        push_pkt(8'h14, 16'd0, 2, 8'h34, s);
        drain("t3b");
        check_writes("t3b", base, 2, QS, s, 99);
        check_eq("t3b_commit_q", last_commit_q, 1);
        // Bits 4 and 5 -> q2 (even queue beats odd)
        base = wr_addr_log.size();
        push_pkt(8'h30, 16'd0, 2, 8'h35, s);
        drain("t3c");
        check_writes("t3c", base, 2, 2 * QS, s, 99);
        check_eq("t3c_commit_q", last_commit_q, 2);

        // Fill q1 up to offset QS-2
        base = wr_addr_log.size();
        push_pkt(8'h04, 16'd16, 28, 8'h41, s);
        drain("t4a");
        check_writes("t4a", base, 28, QS + 2, s, 99);
        check_eq("t4a_free1", free_of(1), 2);
        check_eq("t4a_cptr1", cptr(1), QS - 2);
        // Needs 3 words, only 2 free -> dropped
        base = wr_addr_log.size();
        push_pkt(8'h04, 16'd16, 2, 8'h42, s);
        drain("t4b");
        check_eq("t4b_nwr", wr_addr_log.size(), base);
        check_eq("t4b_drop", drop_cnt, 2);
        // Release 30 to q1, and an out-of-range release that must be ignored
        rel_valid = 1'b1; rel_q = 3'd1; rel_words = 19'd30;
        @(negedge clk);
        rel_q = 3'd5; rel_words = 19'd3;
        @(negedge clk);
        rel_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_rel_free1", free_of(1), QS);
        check_eq("t4_rel_free0", free_of(0), QS - 4);
        check_eq("t4_rel_free4", free_of(4), QS - 3);
        // 4 words across the ring wrap
        base = wr_addr_log.size();
        push_pkt(8'h04, 16'd16, 4, 8'h43, s);
        drain("t4c");
        check_writes("t4c", base, 4, QS + QS - 2, s, 2);
        check_eq("t4c_cptr1", cptr(1), 2);
        check_eq("t4c_free1", free_of(1), QS - 4);

        // Bring free[2] down to 3
        base = wr_addr_log.size();
        push_pkt(8'h10, 16'd16, 27, 8'h51, s);
        drain("t5a");
        check_writes("t5a", base, 27, 2 * QS + 2, s, 99);
        check_eq("t5a_free2", free_of(2), 3);
        // Length claims 3 words (fits exactly), packet really has 6 -> abort after 3
        base = wr_addr_log.size();
        n = commit_cnt;
        push_pkt(8'h10, 16'd16, 6, 8'h52, s);
        drain("t5b");
        check_writes("t5b", base, 3, 2 * QS + 29, s, 99);
        check_eq("t5b_free2", free_of(2), 3);
        check_eq("t5b_drop", drop_cnt, 3);
        check_eq("t5b_commits", commit_cnt, n);
        check_eq("t5b_cptr2", cptr(2), 29);
        // Next packet reuses the rewound offset
        base = wr_addr_log.size();
        push_pkt(8'h10, 16'd0, 2, 8'h53, s);
        drain("t5c");
        check_writes("t5c", base, 2, 2 * QS + 29, s, 99);
        check_eq("t5c_cptr2", cptr(2), 31);
        check_eq("t5c_free2", free_of(2), 1);

        // q0 10 words, SRAM stalls after 3 accepted while reader releases 4/cycle
        base = wr_addr_log.size();
        push_pkt(8'h01, 16'd16, 10, 8'h61, s);
        n = 0;
        while ((wr_addr_log.size() < base + 3) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reach3", wr_addr_log.size(), base + 3);
        sram_if.sram_wr_ready = 1'b0;
        rel_valid = 1'b1; rel_q = 3'd0; rel_words = 19'd4;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            check_eq("t6_stall_req", sram_if.sram_wr_req, 1);
            check_eq("t6_stall_addr", sram_if.sram_wr_addr, 7);
            check_eq("t6_stall_data", sram_if.sram_wr_data, fifo_mem[(s + 3) % 512]);
            check_eq("t6_stall_pop", in_rd_en, 0);
        end
        @(negedge clk);
        sram_if.sram_wr_ready = 1'b1;
        rel_valid = 1'b0;
        check_eq("t6_stall_free0", free_of(0), QS);
        drain("t6");
        check_writes("t6", base, 10, 4, s, 99);
        check_eq("t6_cptr0", cptr(0), 14);
        check_eq("t6_free0", free_of(0), QS - 7);
        check_eq("t6_commit_q", last_commit_q, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
